// File: rtl/vend_pkg.sv
// Shared codes for the vending port arbiter: categories, response status, FSM encoding.
// Also holds the request legality rule used when a panel wins arbitration.
package vend_pkg;

    localparam logic [1:0] CAT_HOT  = 2'b01;
    localparam logic [1:0] CAT_COLD = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_REFUSED = 2'b01;
    localparam logic [1:0] ST_INVALID = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_HOLD  = 3'd4
    } arb_state_t;

    function automatic logic req_legal(input logic [1:0] cat,
                                       input logic [3:0] choice,
                                       input logic [3:0] max_choice);
        return ((cat == CAT_HOT) || (cat == CAT_COLD)) &&
               (choice != 4'd0) && (choice <= max_choice);
    endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from rr+1 (mod N).
// Zero latency; no backpressure, the caller decides when to act on the result.
module vend_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[IW'((int'(rr) + i) % N)]) begin
                any = 1'b1;
                idx = IW'((int'(rr) + i) % N);
            end
        end
        win = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/vend_port_arbiter.sv
// Round-robin share of one vending core among N panels; core_start one cycle after req is sampled.
// Owner keeps grant until it drops req; other panels simply wait, nothing is preempted.
module vend_port_arbiter
    import vend_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int TIMEOUT_CYC = 1023,
    parameter int MAX_CHOICE  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PORTS-1:0]   req,
    input  logic [2*N_PORTS-1:0] req_cat,
    input  logic [4*N_PORTS-1:0] req_choice,
    output logic [N_PORTS-1:0]   grant,
    output logic [N_PORTS-1:0]   done,
    output logic [1:0]           rsp_status,
    output logic                 core_start,
    output logic [1:0]           core_cat,
    output logic [3:0]           core_choice,
    input  logic                 core_done,
    input  logic                 core_ok,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IW = $clog2(N_PORTS);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t state_q, state_d;

    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      rr_q;
    logic [1:0]         cat_q;
    logic [3:0]         choice_q;
    logic [1:0]         status_q;
    logic [CW-1:0]      cnt_q;

    logic [N_PORTS-1:0] pick_win;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [1:0]         sel_cat;
    logic [3:0]         sel_choice;
    logic               pick_legal;
    logic               at_limit;
    logic               owner_req;
    logic [N_PORTS-1:0] owner_oh;

    vend_rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
        .req (req),
        .rr  (rr_q),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_cat    = '0;
        sel_choice = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick_win[i]) begin
                sel_cat    = req_cat[2*i +: 2];
                sel_choice = req_choice[4*i +: 4];
            end
        end
    end

    assign pick_legal = req_legal(sel_cat, sel_choice, 4'(MAX_CHOICE));
    assign at_limit   = (cnt_q == CW'(TIMEOUT_CYC));
    assign owner_req  = req[owner_q];
    assign owner_oh   = {{(N_PORTS-1){1'b0}}, 1'b1} << owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_any) state_d = pick_legal ? S_ISSUE : S_RESP;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (core_done || at_limit) state_d = S_RESP;
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  if (!owner_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status is captured on the way into RESP and held until the owner lets go.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= '0;
            rr_q     <= IW'(N_PORTS - 1);
            cat_q    <= '0;
            choice_q <= '0;
            status_q <= ST_OK;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        owner_q  <= pick_idx;
                        cat_q    <= sel_cat;
                        choice_q <= sel_choice;
                        if (!pick_legal) status_q <= ST_INVALID;
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    if (core_done) begin
                        status_q <= core_ok ? ST_OK : ST_REFUSED;
                    end else if (at_limit) begin
                        status_q <= ST_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (!owner_req) begin
                        rr_q     <= owner_q;
                        status_q <= ST_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant       = '0;
        done        = '0;
        core_start  = 1'b0;
        timeout_err = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_ISSUE: begin
                grant      = owner_oh;
                core_start = 1'b1;
            end
            S_WAIT: begin
                grant       = owner_oh;
                timeout_err = at_limit && !core_done;
            end
            S_RESP: begin
                grant = owner_oh;
                done  = owner_oh;
            end
            S_HOLD:  grant = owner_oh;
            default: ;
        endcase
    end

    assign rsp_status  = status_q;
    assign core_cat    = cat_q;
    assign core_choice = choice_q;

endmodule
